lpif_txrx_x2_asym1_full_dstrm_tx: RTL

//  Master-end downstream transmitter for the x2 asym1 full LPIF link: packs the 75-bit LPIF downstream word

---
 rtl/lpif_txrx_x2_asym1_full_dstrm_tx.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/lpif_txrx_x2_asym1_full_dstrm_tx.sv
// ---------------------------------------------------------------------------
// lpif_txrx_x2_asym1_full_dstrm_tx
//
// Master-end downstream transmitter for the x2 asym1 full LPIF link.
// The 75-bit LPIF downstream word is registered (stage 1). It is then packed
// into two 40-bit PHY lanes (stage 2): bit 39 of each lane is the marker,
// bit 0 is the strobe, and bits 38:1 carry 38 word bits per lane.
// An OFFLINE/SYNC/ONLINE sequencer gates which words reach the pins:
//   OFFLINE : lanes all zero
//   SYNC    : SYNC_CYCLES idle words (payload zero, marker + strobe present)
//   ONLINE  : stage-1 word packed verbatim
// The input-to-pin latency is two cycles.
//
// Parameters
//   STB_INTERVAL  cycles between strobe insertions (2..255)
//   SYNC_CYCLES   idle+strobe words sent before data (1..65535)
//
// Ports
//   clk_wr           link clock
//   rst_wr_n         asynchronous active-low reset
//   tx_online        PHY tx ready; low forces OFFLINE on the next edge
//   tx_mrk_userbit   marker slot value (every SYNC/ONLINE word)
//   tx_stb_userbit   strobe slot value on strobe cycles
//   dstrm_*          LPIF downstream word fields
//   tx_phy0/1        lane 0 / lane 1 (word bits 37:0 / 75:38)
//   tx_link_up       high while words are being packed in ONLINE
//   tx_debug_status  {state[1:0], 2'b0, drop_cnt[11:0], word_cnt[15:0]},
//                    one cycle behind the live state and counters
// ---------------------------------------------------------------------------
module lpif_txrx_x2_asym1_full_dstrm_tx #(
  parameter int STB_INTERVAL = 16,
  parameter int SYNC_CYCLES  = 32
) (
  input  logic        clk_wr,
  input  logic        rst_wr_n,
  input  logic        tx_online,
  input  logic        tx_mrk_userbit,
  input  logic        tx_stb_userbit,
  input  logic [3:0]  dstrm_state,
  input  logic [1:0]  dstrm_protid,
  input  logic [63:0] dstrm_data,
  input  logic        dstrm_dvalid,
  input  logic [1:0]  dstrm_crc,
  input  logic        dstrm_crc_valid,
  input  logic        dstrm_valid,
  output logic [39:0] tx_phy0,
  output logic [39:0] tx_phy1,
  output logic        tx_link_up,
  output logic [31:0] tx_debug_status
);

  localparam int          LANES        = 2;
  localparam int          LANE_PAYLOAD = 38;
  localparam logic [7:0]  STB_LAST     = 8'(STB_INTERVAL - 1);
  localparam logic [15:0] SYNC_LAST    = 16'(SYNC_CYCLES - 1);

  // Encoding is visible in tx_debug_status, so it is fixed explicitly.
  typedef enum logic [1:0] {
    ST_OFFLINE = 2'd0,
    ST_SYNC    = 2'd1,
    ST_ONLINE  = 2'd2
  } seq_state_t;

  seq_state_t               state_reg;
  seq_state_t               state_next;
  logic [15:0]              sync_cnt_reg;
  logic [15:0]              sync_cnt_next;
  logic [7:0]               stb_cnt_reg;
  logic [7:0]               stb_cnt_next;
  logic [7:0]               stb_cnt_step;

  logic [74:0]              s1_word_reg;
  logic                     s1_valid;

  logic                     lane_en;     // marker/strobe slots active
  logic                     payload_en;  // stage-1 word reaches the lanes
  logic                     stb_slot;
  logic [75:0]              word_ext;
  logic [LANES-1:0][39:0]   lane_next;
  logic [LANES-1:0][39:0]   lane_reg;

  logic                     link_up_reg;
  logic                     link_up_next;
  logic [15:0]              word_cnt_reg;
  logic [15:0]              word_cnt_next;
  logic [11:0]              drop_cnt_reg;
  logic [11:0]              drop_cnt_next;
  logic [31:0]              status_reg;
  logic [31:0]              status_next;

  // -------------------------------------------------------------------------
  // Stage 1: capture the downstream word every cycle. Nothing downstream
  // depends on its reset value because the sequencer starts OFFLINE and the
  // counters are held in reset, so it is left without a reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_wr) begin
    s1_word_reg <= {dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
                    dstrm_crc, dstrm_crc_valid, dstrm_valid};
  end

  assign s1_valid = s1_word_reg[0];

  // -------------------------------------------------------------------------
  // Sequencer
  // -------------------------------------------------------------------------
  assign stb_cnt_step = (stb_cnt_reg == STB_LAST) ? 8'd0 : stb_cnt_reg + 8'd1;

  always_comb begin
    state_next    = state_reg;
    sync_cnt_next = sync_cnt_reg;
    stb_cnt_next  = stb_cnt_reg;
    lane_en       = 1'b0;
    payload_en    = 1'b0;

    case (state_reg)
      ST_OFFLINE: begin
        if (tx_online) begin
          state_next    = ST_SYNC;
          sync_cnt_next = 16'd0;
          // Restart the strobe phase so the first SYNC word carries strobe.
          stb_cnt_next  = 8'd0;
        end
      end
      ST_SYNC: begin
        lane_en       = 1'b1;
        stb_cnt_next  = stb_cnt_step;
        sync_cnt_next = sync_cnt_reg + 16'd1;
        if (sync_cnt_reg == SYNC_LAST) begin
          state_next = ST_ONLINE;
        end
      end
      ST_ONLINE: begin
        lane_en      = 1'b1;
        payload_en   = 1'b1;
        stb_cnt_next = stb_cnt_step;
      end
      default: begin
        // Unused encoding: fall back to OFFLINE with quiet lanes.
        state_next = ST_OFFLINE;
      end
    endcase

    // Losing the PHY overrides everything: the word now leaving stage 1 is
    // discarded and the lanes go quiet on this same edge.
    if (!tx_online) begin
      state_next = ST_OFFLINE;
      lane_en    = 1'b0;
      payload_en = 1'b0;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_reg    <= ST_OFFLINE;
      sync_cnt_reg <= 16'd0;
      stb_cnt_reg  <= 8'd0;
    end else begin
      state_reg    <= state_next;
      sync_cnt_reg <= sync_cnt_next;
      stb_cnt_reg  <= stb_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: lane packing. Bit 75 of the extended word is a constant pad so
  // lane 1 carries exactly 38 bits like lane 0.
  // -------------------------------------------------------------------------
  assign stb_slot = (stb_cnt_reg == 8'd0) ? tx_stb_userbit : 1'b0;
  assign word_ext = payload_en ? {1'b0, s1_word_reg} : 76'd0;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_next[gi] = lane_en
        ? {tx_mrk_userbit, word_ext[LANE_PAYLOAD*gi +: LANE_PAYLOAD], stb_slot}
        : 40'd0;
    end
  endgenerate

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      lane_reg <= '0;
    end else begin
      lane_reg <= lane_next;
    end
  end

  assign tx_phy0 = lane_reg[0];
  assign tx_phy1 = lane_reg[1];

  // -------------------------------------------------------------------------
  // Link status and statistics. A valid word leaving stage 1 is either sent
  // (ONLINE with PHY ready) or dropped; the drop counter sticks at all-ones.
  // -------------------------------------------------------------------------
  assign link_up_next  = payload_en;
  assign word_cnt_next = word_cnt_reg + 16'(payload_en & s1_valid);
  assign drop_cnt_next = (!payload_en && s1_valid && (drop_cnt_reg != 12'hFFF))
                         ? drop_cnt_reg + 12'd1
                         : drop_cnt_reg;
  assign status_next   = {state_reg, 2'b00, drop_cnt_reg, word_cnt_reg};

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      link_up_reg  <= 1'b0;
      word_cnt_reg <= 16'd0;
      drop_cnt_reg <= 12'd0;
      status_reg   <= 32'd0;
    end else begin
      link_up_reg  <= link_up_next;
      word_cnt_reg <= word_cnt_next;
      drop_cnt_reg <= drop_cnt_next;
      status_reg   <= status_next;
    end
  end

  assign tx_link_up      = link_up_reg;
  assign tx_debug_status = status_reg;

endmodule
